// File: rtl/water_supply_sequencer.sv
// water_supply_sequencer: one shared pump feeding CHANNELS tanks.
// Each channel debounces its low/high level sensors and runs its own
// IDLE/FILL/HOLDOFF/FAULT state machine. Only one channel may fill at a time,
// and the lowest-index waiting channel gets the pump.
// Optional feature: define WATER_SUPPLY_FILL_TIMEOUT_EN to fault a channel
// that stays in FILL for FILL_TIMEOUT cycles. Without it there is no fill
// counter and FILL_TIMEOUT is only range-checked.
module water_supply_sequencer #(
  parameter int CHANNELS        = 2,
  parameter int VALVE_WIDTH     = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FILL_TIMEOUT    = 1000,
  parameter int REFILL_HOLDOFF  = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [CHANNELS-1:0]             low_water_level,
  input  logic [CHANNELS-1:0]             high_water_level,
  input  logic                            fault_clear,
  output logic [CHANNELS*VALVE_WIDTH-1:0] valvule,
  output logic [CHANNELS-1:0]             filling,
  output logic [CHANNELS-1:0]             fault
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  // Run-length counter only needs to reach DEBOUNCE_CYCLES.
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  // Holdoff counter counts 0..HOLD_LAST, so HOLDOFF lasts REFILL_HOLDOFF cycles.
  localparam int HOLD_LAST = (REFILL_HOLDOFF > 1) ? REFILL_HOLDOFF - 1 : 0;
  localparam int HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

  localparam logic [VALVE_WIDTH-1:0] VALVE_CLOSED = {VALVE_WIDTH{1'b1}};
  localparam logic [VALVE_WIDTH-1:0] VALVE_OPEN   = {{(VALVE_WIDTH-1){1'b1}}, 1'b0};

  // Reject parameter sets the design was never meant to handle.
  if (CHANNELS < 1 || CHANNELS > 8 || VALVE_WIDTH < 2 ||
      DEBOUNCE_CYCLES < 1 || FILL_TIMEOUT < 1) begin : g_bad_params
    $error("water_supply_sequencer: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Sensor debouncing. Bits [CHANNELS-1:0] are the low sensors, the upper
  // CHANNELS bits the high sensors; every bit is filtered on its own.
  // ---------------------------------------------------------------------------
  logic [2*CHANNELS-1:0] sense_raw;
  logic [2*CHANNELS-1:0] sense_db;

  assign sense_raw = {high_water_level, low_water_level};

  for (genvar gi = 0; gi < 2*CHANNELS; gi++) begin : g_debounce
    // Low sensors come out of reset reading "water present", high sensors not.
    localparam logic RESET_LEVEL = (gi < CHANNELS);

    logic            sample_reg;
    logic            level_reg;
    logic [DB_W-1:0] run_cnt_reg;
    logic [DB_W-1:0] run_cnt_next;

    // Length of the current run of identical samples, saturating.
    always_comb begin
      run_cnt_next = DB_W'(1);
      if (sense_raw[gi] == sample_reg) begin
        if (run_cnt_reg == DB_W'(DEBOUNCE_CYCLES)) begin
          run_cnt_next = run_cnt_reg;
        end else begin
          run_cnt_next = run_cnt_reg + DB_W'(1);
        end
      end
    end

    // Accept the raw value on the edge its run reaches DEBOUNCE_CYCLES.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sample_reg  <= RESET_LEVEL;
        level_reg   <= RESET_LEVEL;
        run_cnt_reg <= '0;
      end else begin
        sample_reg  <= sense_raw[gi];
        run_cnt_reg <= run_cnt_next;
        if (run_cnt_next == DB_W'(DEBOUNCE_CYCLES)) begin
          level_reg <= sense_raw[gi];
        end
      end
    end

    assign sense_db[gi] = level_reg;
  end

  // ---------------------------------------------------------------------------
  // Pump arbitration: nobody starts while any channel is filling, otherwise
  // the lowest-index waiting channel is granted.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] fill_state;
  logic [CHANNELS-1:0] candidate;
  logic [CHANNELS-1:0] grant;
  logic                any_fill;

  assign any_fill = |fill_state;
  assign grant    = any_fill ? '0 : (candidate & (~candidate + CHANNELS'(1)));

  // ---------------------------------------------------------------------------
  // Per-channel state machine.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
    state_t            state_reg;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              db_low;
    logic              db_high;
    logic              conflict;
    logic              hold_done;
    logic              timeout;

    assign db_low    = sense_db[gi];
    assign db_high   = sense_db[CHANNELS + gi];
    // Water above the high mark but not above the low mark is impossible.
    assign conflict  = db_high & ~db_low;
    assign hold_done = (hold_cnt_reg == HOLD_W'(HOLD_LAST));

    assign candidate[gi] = (state_reg == ST_IDLE) && !db_low && !conflict;

`ifdef WATER_SUPPLY_FILL_TIMEOUT_EN
    localparam int FILL_LAST = FILL_TIMEOUT - 1;
    localparam int FILL_W    = (FILL_LAST > 0) ? $clog2(FILL_LAST + 1) : 1;

    logic [FILL_W-1:0] fill_cnt_reg;
    logic [FILL_W-1:0] fill_cnt_next;

    // This edge is the FILL_TIMEOUT-th spent in FILL.
    assign timeout = (fill_cnt_reg == FILL_W'(FILL_LAST));

    // Time spent in FILL; zero outside FILL so every entry restarts it.
    always_comb begin
      fill_cnt_next = '0;
      if (state_reg == ST_FILL && state_next == ST_FILL) begin
        fill_cnt_next = timeout ? fill_cnt_reg : fill_cnt_reg + FILL_W'(1);
      end
    end

    // Fill counter register.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        fill_cnt_reg <= '0;
      end else begin
        fill_cnt_reg <= fill_cnt_next;
      end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic; a sensor conflict overrides every other transition.
    always_comb begin
      state_next    = state_reg;
      hold_cnt_next = '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant[gi]) begin
            state_next = ST_FILL;
          end
        end
        ST_FILL: begin
          if (db_high) begin
            state_next = ST_HOLDOFF;
          end else if (timeout) begin
            state_next = ST_FAULT;
          end
        end
        ST_HOLDOFF: begin
          if (hold_done) begin
            state_next = ST_IDLE;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
        ST_FAULT: begin
          if (fault_clear) begin
            state_next = ST_HOLDOFF;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
      if (conflict) begin
        state_next    = ST_FAULT;
        hold_cnt_next = '0;
      end
    end

    // State and holdoff counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_reg    <= ST_IDLE;
        hold_cnt_reg <= '0;
      end else begin
        state_reg    <= state_next;
        hold_cnt_reg <= hold_cnt_next;
      end
    end

    // Outputs decode straight from the state register, so reset closes the
    // valve as soon as reset_n falls.
    assign fill_state[gi] = (state_reg == ST_FILL);
    assign filling[gi]    = fill_state[gi];
    assign fault[gi]      = (state_reg == ST_FAULT);
    assign valvule[gi*VALVE_WIDTH +: VALVE_WIDTH] =
      fill_state[gi] ? VALVE_OPEN : VALVE_CLOSED;
  end

endmodule

// File: tb/tb_water_supply_sequencer.sv
// tb_water_supply_sequencer: directed scenarios with fixed expected values,
// then randomized tank levels, all compared every cycle against a
// behavioural model of the sequencer.
module tb_water_supply_sequencer;

  localparam int N  = 2;
  localparam int VW = 4;
  localparam int DB = 4;
  localparam int FT = 20;
  localparam int HO = 8;

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_FAULT = 3;

`ifdef WATER_SUPPLY_FILL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    low_water_level;
  logic [N-1:0]    high_water_level;
  logic            fault_clear;
  logic [N*VW-1:0] valvule;
  logic [N-1:0]    filling;
  logic [N-1:0]    fault;

  int n_checks = 0;
  int n_errors = 0;

  water_supply_sequencer #(
    .CHANNELS        (N),
    .VALVE_WIDTH     (VW),
    .DEBOUNCE_CYCLES (DB),
    .FILL_TIMEOUT    (FT),
    .REFILL_HOLDOFF  (HO)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .low_water_level  (low_water_level),
    .high_water_level (high_water_level),
    .fault_clear      (fault_clear),
    .valvule          (valvule),
    .filling          (filling),
    .fault            (fault)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int           m_state[N];
  int           m_hold_left[N];
  int           m_fill_age[N];
  bit           m_db_lo[N];
  bit           m_db_hi[N];
  logic [DB-1:0] m_lo_hist[N];
  logic [DB-1:0] m_hi_hist[N];
  int           m_seen[N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_state[c]     = M_IDLE;
      m_hold_left[c] = 0;
      m_fill_age[c]  = 0;
      m_db_lo[c]     = 1'b1;
      m_db_hi[c]     = 1'b0;
      m_lo_hist[c]   = '0;
      m_hi_hist[c]   = '0;
      m_seen[c]      = 0;
    end
  endtask

  task automatic model_step();
    bit conf[N];
    bit any_fill;
    int winner;
    any_fill = 1'b0;
    winner   = -1;
    for (int c = 0; c < N; c++) begin
      conf[c] = m_db_hi[c] && !m_db_lo[c];
      if (m_state[c] == M_FILL) any_fill = 1'b1;
    end
    for (int c = 0; c < N; c++) begin
      if (winner < 0 && m_state[c] == M_IDLE && !m_db_lo[c] && !conf[c]) winner = c;
    end
    for (int c = 0; c < N; c++) begin
      if (conf[c]) begin
        m_state[c] = M_FAULT;
      end else begin
        case (m_state[c])
          M_IDLE: begin
            if (!any_fill && winner == c) begin
              m_state[c]    = M_FILL;
              m_fill_age[c] = 0;
            end
          end
          M_FILL: begin
            m_fill_age[c]++;
            if (m_db_hi[c]) begin
              m_state[c]     = M_HOLD;
              m_hold_left[c] = HO;
            end else if (TIMEOUT_EN && m_fill_age[c] >= FT) begin
              m_state[c] = M_FAULT;
            end
          end
          M_HOLD: begin
            m_hold_left[c]--;
            if (m_hold_left[c] <= 0) m_state[c] = M_IDLE;
          end
          default: begin
            if (fault_clear) begin
              m_state[c]     = M_HOLD;
              m_hold_left[c] = HO;
            end
          end
        endcase
      end
    end
    // A sensor reading is accepted once its last DB samples all agree.
    for (int c = 0; c < N; c++) begin
      m_seen[c]    = (m_seen[c] < DB) ? m_seen[c] + 1 : DB;
      m_lo_hist[c] = {m_lo_hist[c][DB-2:0], low_water_level[c]};
      m_hi_hist[c] = {m_hi_hist[c][DB-2:0], high_water_level[c]};
      if (m_seen[c] == DB) begin
        if (&m_lo_hist[c] || ~|m_lo_hist[c]) m_db_lo[c] = m_lo_hist[c][0];
        if (&m_hi_hist[c] || ~|m_hi_hist[c]) m_db_hi[c] = m_hi_hist[c][0];
      end
    end
  endtask

  function automatic logic [N*VW-1:0] exp_valvule();
    logic [N*VW-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++) r[c*VW +: VW] = (m_state[c] == M_FILL) ? 4'hE : 4'hF;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_filling();
    logic [N-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++) r[c] = (m_state[c] == M_FILL);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_fault();
    logic [N-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++) r[c] = (m_state[c] == M_FAULT);
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clock) begin
    check_value("model_valvule", 32'(valvule), 32'(exp_valvule()));
    check_value("model_filling", 32'(filling), 32'(exp_filling()));
    check_value("model_fault",   32'(fault),   32'(exp_fault()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    low_water_level  = 2'b11;
    high_water_level = 2'b00;
    fault_clear      = 1'b0;
    tick(2);
    check_value("reset_valvule", 32'(valvule), 32'h0000_00FF);
    check_value("reset_filling", 32'(filling), 32'h0);
    check_value("reset_fault",   32'(fault),   32'h0);
    reset_n = 1'b1;
    tick(6);
  endtask

  int lvl[N];
  int left[N];
  int r;

  initial begin
    model_reset();
    low_water_level  = 2'b11;
    high_water_level = 2'b00;
    fault_clear      = 1'b0;
    tick(1);
    do_reset();

    // Basic fill cycle, hysteresis and holdoff length.
    low_water_level[0] = 1'b0;
    tick(4);
    check_value("fill_not_yet", 32'(valvule), 32'h0000_00FF);
    tick(1);
    check_value("fill_open", 32'(valvule), 32'h0000_00FE);
    check_value("fill_flag", 32'(filling), 32'h1);
    low_water_level[0] = 1'b1;
    tick(6);
    check_value("hysteresis", 32'(valvule), 32'h0000_00FE);
    high_water_level[0] = 1'b1;
    tick(4);
    check_value("high_not_yet", 32'(valvule), 32'h0000_00FE);
    tick(1);
    check_value("fill_stop", 32'(valvule), 32'h0000_00FF);
    low_water_level[0]  = 1'b0;
    high_water_level[0] = 1'b0;
    tick(8);
    check_value("holdoff_closed", 32'(valvule), 32'h0000_00FF);
    tick(1);
    check_value("refill_after_holdoff", 32'(valvule), 32'h0000_00FE);

    // Short glitch on the low sensor is filtered out.
    do_reset();
    low_water_level[0] = 1'b0;
    tick(3);
    low_water_level[0] = 1'b1;
    tick(10);
    check_value("glitch_valvule", 32'(valvule), 32'h0000_00FF);
    check_value("glitch_filling", 32'(filling), 32'h0);

    // Both channels empty together: channel 0 first, channel 1 afterwards.
    do_reset();
    low_water_level = 2'b00;
    tick(5);
    check_value("arb_ch0_first", 32'(valvule), 32'h0000_00FE);
    low_water_level = 2'b01;
    tick(6);
    check_value("arb_ch1_waits", 32'(valvule), 32'h0000_00FE);
    high_water_level = 2'b01;
    tick(5);
    check_value("arb_gap", 32'(valvule), 32'h0000_00FF);
    tick(1);
    check_value("arb_ch1_fills", 32'(valvule), 32'h0000_00EF);
    check_value("arb_ch1_flag", 32'(filling), 32'h2);

    // Sensor conflict on channel 1, then clearing the fault.
    high_water_level = 2'b11;
    tick(5);
    check_value("conflict_fault", 32'(fault), 32'h2);
    check_value("conflict_valve", 32'(valvule), 32'h0000_00FF);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    check_value("clear_ignored", 32'(fault), 32'h2);
    high_water_level = 2'b01;
    tick(6);
    check_value("fault_held", 32'(fault), 32'h2);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    check_value("fault_cleared", 32'(fault), 32'h0);
    check_value("cleared_closed", 32'(valvule), 32'h0000_00FF);

    // Fill that never reaches the high mark.
    do_reset();
    low_water_level = 2'b10;
    tick(5);
    check_value("long_fill_open", 32'(valvule), 32'h0000_00FE);
`ifdef WATER_SUPPLY_FILL_TIMEOUT_EN
    tick(19);
    check_value("timeout_not_yet", 32'(fault), 32'h0);
    tick(1);
    check_value("timeout_fault", 32'(fault), 32'h1);
    check_value("timeout_closed", 32'(valvule), 32'h0000_00FF);
`else
    tick(100);
    check_value("no_timeout_fill", 32'(filling), 32'h1);
    check_value("no_timeout_valve", 32'(valvule), 32'h0000_00FE);
`endif

    // Asynchronous reset in the middle of a fill.
    do_reset();
    low_water_level = 2'b10;
    tick(7);
    #2 reset_n = 1'b0;
    #1;
    check_value("async_valvule", 32'(valvule), 32'h0000_00FF);
    check_value("async_filling", 32'(filling), 32'h0);
    check_value("async_fault",   32'(fault),   32'h0);
    tick(1);
    do_reset();

    // Randomized tank levels; levels: 0 empty, 1 mid, 2 full, 3 conflict.
    for (int c = 0; c < N; c++) begin
      lvl[c]  = 1;
      left[c] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (left[c] == 0) begin
          r       = $urandom_range(0, 19);
          lvl[c]  = (r < 1) ? 3 : (r < 7) ? 0 : (r < 14) ? 1 : 2;
          left[c] = $urandom_range(1, 14);
        end
        left[c]--;
        low_water_level[c]  = (lvl[c] == 1 || lvl[c] == 2);
        high_water_level[c] = (lvl[c] == 2 || lvl[c] == 3);
      end
      fault_clear = ($urandom_range(0, 9) == 0);
      tick(1);
    end
    fault_clear = 1'b0;
    tick(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/water_supply_sequencer.md
WATER_SUPPLY_SEQUENCER -- requirements
Module: water_supply_sequencer

Interface
REQ-001 Parameter CHANNELS, default 2: number of tank/valve channels, 1..8.
REQ-002 Parameter VALVE_WIDTH, default 4: width of each channel's valve code, >=2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive equal samples needed before a sensor change is accepted, >=1.
REQ-004 Parameter FILL_TIMEOUT, default 1000: maximum cycles a channel may stay in FILL.
REQ-005 Parameter REFILL_HOLDOFF, default 16: cycles a channel stays closed after a fill ends or a fault clears.
REQ-006 clock  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 low_water_level  input  CHANNELS  1 = water at or above the low mark, per channel.
REQ-009 high_water_level  input  CHANNELS  1 = water at or above the high mark, per channel.
REQ-010 fault_clear  input  1  single-cycle request to leave FAULT, applies to all channels.
REQ-011 valvule  output  CHANNELS*VALVE_WIDTH  valve codes; channel i occupies bits [i*VALVE_WIDTH +: VALVE_WIDTH].
REQ-012 filling  output  CHANNELS  1 while channel is in FILL.
REQ-013 fault  output  CHANNELS  1 while channel is in FAULT.

Function
REQ-014 Valve code SHALL be all ones when closed, and all ones except bit 0 = 0 when open; open only in FILL.
REQ-015 Each sensor bit SHALL be debounced independently; the debounced value takes the raw value on the edge where the raw value has been sampled unchanged for DEBOUNCE_CYCLES consecutive edges.
REQ-016 Conflict for channel i SHALL be debounced high = 1 AND debounced low = 0.
REQ-017 Per-channel FSM states SHALL be IDLE, FILL, HOLDOFF and FAULT; outputs are decoded from the state register with no added latency.
REQ-018 IDLE->FILL SHALL occur when debounced low = 0, there is no conflict, no channel is in FILL, and no lower-index channel also qualifies this cycle: one shared pump, lowest index wins.
REQ-019 FILL->HOLDOFF SHALL occur when debounced high = 1 without conflict; the hysteresis band is between the low and high marks.
REQ-020 HOLDOFF SHALL last exactly REFILL_HOLDOFF cycles, then go to IDLE.
REQ-021 A conflict in any state SHALL force FAULT on the next edge; conflict takes priority over every other transition.
REQ-022 FAULT->HOLDOFF SHALL occur only when fault_clear = 1 and the channel has no conflict; otherwise fault_clear is ignored.
REQ-023 Counters SHALL saturate and never wrap; the FILL counter is cleared on FILL entry.

Reset
REQ-024 While reset_n = 0, every channel SHALL be IDLE with valvule all ones, filling = 0, fault = 0, and all counters = 0.
REQ-025 Debounced low SHALL reset to 1 and debounced high SHALL reset to 0.
REQ-026 Reset asserted mid-fill SHALL close the valve immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro WATER_SUPPLY_FILL_TIMEOUT_EN defined: a channel reaching FILL_TIMEOUT cycles in FILL SHALL go to FAULT.
REQ-028 Macro WATER_SUPPLY_FILL_TIMEOUT_EN undefined: there SHALL be no fill counter, FILL exits only per REQ-019 and REQ-021, and FILL_TIMEOUT is unused.

Verification (CHANNELS=2, VALVE_WIDTH=4, DEBOUNCE_CYCLES=4, FILL_TIMEOUT=20, REFILL_HOLDOFF=8)
REQ-029 Release reset, ch0 low 1->0 held -> valvule = 8'hFE exactly 5 edges later, filling = 2'b01; raise high -> 8'hFF, 8 cycles in HOLDOFF, then IDLE.
REQ-030 ch0 low pulses 0 for 3 cycles only -> valvule stays 8'hFF.
REQ-031 Both channels drop low on the same edge -> ch0 fills first (8'hFE); ch1 fills (8'hEF) only after ch0 leaves FILL.
REQ-032 ch1 high = 1 and low = 0 during FILL -> fault = 2'b10, valvule = 8'hFF; fault_clear while conflict persists -> stays FAULT; clear after conflict gone -> HOLDOFF.
REQ-033 With WATER_SUPPLY_FILL_TIMEOUT_EN defined, hold ch0 in FILL without high -> fault[0] = 1 after 20 cycles in FILL; without the macro -> still filling after 100 cycles.
REQ-034 reset_n = 0 asynchronously mid-fill -> valvule = 8'hFF before the next clock edge; all outputs at reset values.
